// File: rtl/spad_pkg.sv
// spad_pkg
// Shared definitions for the weight scratchpad controller:
//   - default weight word width and scratchpad depth
//   - FSM state encoding (plain 2-bit constants for tools that predate enums)
package spad_pkg;

  localparam int WEIGHT_DW_DEF = 32;
  localparam int DEPTH_DEF     = 8;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;
  localparam logic [1:0] ST_RUN    = 2'd3;

endpackage

// File: rtl/spad_addr_cnt.sv
// spad_addr_cnt
// Modulo-DEPTH address counter used for both the scratchpad write and read
// pointers.
// Ports:
//   sclk  in   clock
//   rst   in   asynchronous active-high reset, clears the count
//   clr   in   synchronous clear (wins over en)
//   en    in   advance by one, wrapping DEPTH-1 -> 0
//   cnt   out  current count
//   wrap  out  count is DEPTH-1 (the next advance wraps)
module spad_addr_cnt #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          sclk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [AW-1:0] cnt,
  output logic          wrap
);

  logic [AW-1:0] cnt_q;
  logic [AW-1:0] cnt_d;

  // DEPTH need not be a power of two, so the wrap is an explicit compare
  // rather than natural overflow.
  assign wrap = (cnt_q == AW'(DEPTH - 1));
  assign cnt  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = wrap ? '0 : cnt_q + AW'(1);
    end
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spad_w_ctrl.sv
// spad_w_ctrl
// Weight scratchpad controller: loads DEPTH weight words from an upstream
// valid/ready stream into a scratchpad, then streams the scratchpad to a PE
// for pass_cfg full sweeps, pulsing done when the last sweep completes.
// Ports:
//   sclk, rst                      clock, asynchronous active-high reset
//   load_start, pass_cfg           start request and sweep count (0 means 1)
//   w_valid, w_data, w_ready       upstream weight stream
//   spad_we_en, spad_addr_we,
//   spad_data_in                   registered scratchpad write port
//   spad_addr_re                   scratchpad read address
//   pe_ready, pe_valid, pe_last    downstream PE handshake, last-of-sweep flag
//   busy, done                     status
module spad_w_ctrl
  import spad_pkg::*;
#(
  parameter int WEIGHT_DW = WEIGHT_DW_DEF,
  parameter int DEPTH     = DEPTH_DEF
) (
  input  logic                 sclk,
  input  logic                 rst,
  input  logic                 load_start,
  input  logic [7:0]           pass_cfg,
  input  logic                 w_valid,
  input  logic [WEIGHT_DW-1:0] w_data,
  output logic                 w_ready,
  output logic                 spad_we_en,
  output logic [$clog2(DEPTH)-1:0] spad_addr_we,
  output logic [WEIGHT_DW-1:0] spad_data_in,
  output logic [$clog2(DEPTH)-1:0] spad_addr_re,
  input  logic                 pe_ready,
  output logic                 pe_valid,
  output logic                 pe_last,
  output logic                 busy,
  output logic                 done
);

  localparam int AW = $clog2(DEPTH);

  state_t               state_q, state_d;
  logic [7:0]           pass_q, pass_d;
  logic [7:0]           sweep_q, sweep_d;
  logic                 w_ready_q, w_ready_d;
  logic                 we_en_q, we_en_d;
  logic [AW-1:0]        addr_we_q, addr_we_d;
  logic [WEIGHT_DW-1:0] data_in_q, data_in_d;
  logic                 done_q, done_d;

  logic          start;
  logic          accept;
  logic          xfer;
  logic [AW-1:0] wr_cnt;
  logic          wr_wrap;
  logic          rd_cnt;
  logic          rd_wrap;
  logic [AW-1:0] rd_addr;

  // w_ready_q is only ever high in LOAD, so it alone qualifies a write beat.
  assign start    = (state_q == ST_IDLE) && load_start;
  assign accept   = w_valid && w_ready_q;
  assign pe_valid = (state_q == ST_RUN);
  assign xfer     = pe_valid && pe_ready;
  assign rd_cnt   = xfer;

  spad_addr_cnt #(.DEPTH(DEPTH), .AW(AW)) u_wr_cnt (
    .sclk (sclk),
    .rst  (rst),
    .clr  (start),
    .en   (accept),
    .cnt  (wr_cnt),
    .wrap (wr_wrap)
  );

  spad_addr_cnt #(.DEPTH(DEPTH), .AW(AW)) u_rd_cnt (
    .sclk (sclk),
    .rst  (rst),
    .clr  (start),
    .en   (rd_cnt),
    .cnt  (rd_addr),
    .wrap (rd_wrap)
  );

  // Sequencing: IDLE -> LOAD (DEPTH beats) -> SETTLE (one cycle so the last
  // write lands before any read) -> RUN (pass_q sweeps) -> IDLE with done.
  always_comb begin
    state_d   = state_q;
    pass_d    = pass_q;
    sweep_d   = sweep_q;
    done_d    = 1'b0;
    we_en_d   = accept;
    addr_we_d = addr_we_q;
    data_in_d = data_in_q;

    if (accept) begin
      addr_we_d = wr_cnt;
      data_in_d = w_data;
    end

    case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          state_d = ST_LOAD;
          pass_d  = (pass_cfg == 8'd0) ? 8'd1 : pass_cfg;
          sweep_d = 8'd0;
        end
      end
      ST_LOAD: begin
        if (accept && wr_wrap) begin
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (xfer && rd_wrap) begin
          if (sweep_q == pass_q - 8'd1) begin
            state_d = ST_IDLE;
            sweep_d = 8'd0;
            done_d  = 1'b1;
          end else begin
            sweep_d = sweep_q + 8'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    w_ready_d = (state_d == ST_LOAD);
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pass_q    <= 8'd0;
      sweep_q   <= 8'd0;
      w_ready_q <= 1'b0;
      we_en_q   <= 1'b0;
      addr_we_q <= '0;
      data_in_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pass_q    <= pass_d;
      sweep_q   <= sweep_d;
      w_ready_q <= w_ready_d;
      we_en_q   <= we_en_d;
      addr_we_q <= addr_we_d;
      data_in_q <= data_in_d;
      done_q    <= done_d;
    end
  end

  assign w_ready      = w_ready_q;
  assign spad_we_en   = we_en_q;
  assign spad_addr_we = addr_we_q;
  assign spad_data_in = data_in_q;
  assign spad_addr_re = rd_addr;
  assign pe_last      = pe_valid && rd_wrap;
  assign busy         = (state_q != ST_IDLE);
  assign done         = done_q;

endmodule

// File: tb/tb_spad_w_ctrl.sv
// tb_spad_w_ctrl
// Self-checking bench for spad_w_ctrl (DEPTH=8, WEIGHT_DW=32). A phase-level
// reference model (load count, settle, total read beats) predicts every
// output each cycle from the stimulus the bench itself drives.
module tb_spad_w_ctrl;

  localparam int DEPTH = 8;
  localparam int DW    = 32;
  localparam int AW    = 3;

  localparam int P_START  = 0;
  localparam int P_LOAD   = 1;
  localparam int P_SETTLE = 2;
  localparam int P_RUN    = 3;
  localparam int P_IDLE   = 4;

  logic          sclk;
  logic          rst;
  logic          load_start;
  logic [7:0]    pass_cfg;
  logic          w_valid;
  logic [DW-1:0] w_data;
  logic          w_ready;
  logic          spad_we_en;
  logic [AW-1:0] spad_addr_we;
  logic [DW-1:0] spad_data_in;
  logic [AW-1:0] spad_addr_re;
  logic          pe_ready;
  logic          pe_valid;
  logic          pe_last;
  logic          busy;
  logic          done;

  int checks;
  int errors;

  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_data;

  spad_w_ctrl #(.WEIGHT_DW(DW), .DEPTH(DEPTH)) dut (
    .sclk         (sclk),
    .rst          (rst),
    .load_start   (load_start),
    .pass_cfg     (pass_cfg),
    .w_valid      (w_valid),
    .w_data       (w_data),
    .w_ready      (w_ready),
    .spad_we_en   (spad_we_en),
    .spad_addr_we (spad_addr_we),
    .spad_data_in (spad_data_in),
    .spad_addr_re (spad_addr_re),
    .pe_ready     (pe_ready),
    .pe_valid     (pe_valid),
    .pe_last      (pe_last),
    .busy         (busy),
    .done         (done)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  // One complete load-and-run operation, checked every cycle against the
  // phase model. abort_at >= 0 pulses reset when the read beat count hits it.
  task automatic run_op(input int pcfg, input int vmode, input int rpct,
                        input int stall_at, input int stall_len, input int abort_at,
                        input bit ign, input bit fixed_words, input int exp_lat);
    logic [DW-1:0] words [DEPTH];
    int ph, acc, beats, npass, cyc, done_cyc, wr_seen, xfer_seen, stall_left;
    bit we_exp, done_exp, tog, finished;
    logic [AW-1:0] exp_re;
    npass = (pcfg == 0) ? 1 : pcfg;
    for (int i = 0; i < DEPTH; i++) begin
      words[i] = fixed_words ? DW'((i + 1) * 'h11) : $urandom;
    end
    ph = P_START; acc = 0; beats = 0; cyc = 1; done_cyc = 0;
    wr_seen = 0; xfer_seen = 0; stall_left = stall_len; tog = 1'b0; finished = 1'b0;
    @(negedge sclk);
    load_start = 1'b1; pass_cfg = 8'(pcfg); w_valid = 1'b0; pe_ready = 1'b0;
    for (int guard = 0; guard < 3000; guard++) begin
      @(negedge sclk);
      cyc++;
      we_exp = 1'b0; done_exp = 1'b0;
      case (ph)
        P_START: ph = P_LOAD;
        P_LOAD: if (w_valid) begin
          we_exp = 1'b1; last_addr = AW'(acc); last_data = words[acc]; acc++;
          if (acc == DEPTH) ph = P_SETTLE;
        end
        P_SETTLE: ph = P_RUN;
        P_RUN: if (pe_ready) begin
          beats++;
          if (beats == DEPTH * npass) begin ph = P_IDLE; done_exp = 1'b1; end
        end
        default: ;
      endcase
      exp_re = AW'(beats % DEPTH);
      checks++; if (w_ready !== (ph == P_LOAD)) begin errors++; $display("[TB] FAIL w_ready cyc=%0d got=%b exp=%b", cyc, w_ready, ph == P_LOAD); end
      checks++; if (spad_we_en !== we_exp) begin errors++; $display("[TB] FAIL spad_we_en cyc=%0d got=%b exp=%b", cyc, spad_we_en, we_exp); end
      checks++; if (spad_addr_we !== last_addr) begin errors++; $display("[TB] FAIL spad_addr_we cyc=%0d got=%0d exp=%0d", cyc, spad_addr_we, last_addr); end
      checks++; if (spad_data_in !== last_data) begin errors++; $display("[TB] FAIL spad_data_in cyc=%0d got=%h exp=%h", cyc, spad_data_in, last_data); end
      checks++; if (pe_valid !== (ph == P_RUN)) begin errors++; $display("[TB] FAIL pe_valid cyc=%0d got=%b exp=%b", cyc, pe_valid, ph == P_RUN); end
      checks++; if (spad_addr_re !== exp_re) begin errors++; $display("[TB] FAIL spad_addr_re cyc=%0d got=%0d exp=%0d", cyc, spad_addr_re, exp_re); end
      checks++; if (pe_last !== (ph == P_RUN && exp_re == AW'(DEPTH - 1))) begin errors++; $display("[TB] FAIL pe_last cyc=%0d got=%b", cyc, pe_last); end
      checks++; if (busy !== (ph != P_IDLE)) begin errors++; $display("[TB] FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, ph != P_IDLE); end
      checks++; if (done !== done_exp) begin errors++; $display("[TB] FAIL done cyc=%0d got=%b exp=%b", cyc, done, done_exp); end
      if (spad_we_en === 1'b1) wr_seen++;
      if (done === 1'b1 && done_cyc == 0) done_cyc = cyc;
      if (abort_at >= 0 && ph == P_RUN && beats == abort_at) begin
        rst = 1'b1;
        #1;
        checks++;
        if ({w_ready, spad_we_en, spad_addr_we, spad_data_in, spad_addr_re, pe_valid, pe_last, busy, done} !== '0) begin
          errors++; $display("[TB] FAIL reset_async_zero got busy=%b pe_valid=%b addr_re=%0d exp all zero", busy, pe_valid, spad_addr_re);
        end
        @(negedge sclk);
        checks++;
        if ({w_ready, spad_we_en, pe_valid, busy, done} !== '0) begin
          errors++; $display("[TB] FAIL reset_held_zero got busy=%b done=%b exp 0", busy, done);
        end
        rst = 1'b0; load_start = 1'b0; w_valid = 1'b0; pe_ready = 1'b0;
        last_addr = '0; last_data = '0;
        return;
      end
      if (ph == P_IDLE) begin finished = 1'b1; break; end
      load_start = ign ? 1'($urandom_range(0, 1)) : 1'b0;
      pass_cfg = 8'($urandom);
      tog = ~tog;
      if (ph == P_LOAD) begin
        w_valid = (vmode == 0) ? 1'b1 : (vmode == 1) ? tog : 1'($urandom_range(0, 1));
        w_data  = words[acc];
      end else begin
        w_valid = 1'($urandom_range(0, 1));
        w_data  = $urandom;
      end
      if (ph == P_RUN && beats == stall_at && stall_left > 0) begin
        pe_ready = 1'b0; stall_left--;
      end else begin
        pe_ready = ($urandom_range(1, 100) <= rpct);
      end
      if (ph == P_RUN && pe_valid === 1'b1 && pe_ready) xfer_seen++;
    end
    load_start = 1'b0; w_valid = 1'b0;
    if (!finished) begin
      errors++; $display("[TB] FAIL timeout got no completion exp done within 3000 cycles");
      return;
    end
    checks++; if (wr_seen != DEPTH) begin errors++; $display("[TB] FAIL write_count got=%0d exp=%0d", wr_seen, DEPTH); end
    checks++; if (xfer_seen != DEPTH * npass) begin errors++; $display("[TB] FAIL read_beats got=%0d exp=%0d", xfer_seen, DEPTH * npass); end
    if (exp_lat > 0) begin
      checks++; if (done_cyc != exp_lat) begin errors++; $display("[TB] FAIL done_latency got=%0d exp=%0d", done_cyc, exp_lat); end
    end
    @(negedge sclk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL done_single got done=%b busy=%b exp 0 0", done, busy); end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({w_ready, spad_we_en, spad_addr_we, spad_data_in, spad_addr_re, pe_valid, pe_last, busy, done} !== '0) begin
      errors++; $display("[TB] FAIL reset_outputs got busy=%b w_ready=%b exp all zero", busy, w_ready);
    end
    @(negedge sclk);
    rst = 1'b0;
    @(negedge sclk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL reset_release got busy=%b done=%b exp 0 0", busy, done); end
  endtask

  task automatic test_basic();
    $display("[TB] basic: two sweeps, back-to-back load");
    run_op(2, 0, 100, -1, 0, -1, 1'b0, 1'b1, 1 + DEPTH + 1 + DEPTH * 2 + 1);
  endtask

  task automatic test_valid_toggle();
    $display("[TB] toggling w_valid");
    run_op(1, 1, 100, -1, 0, -1, 1'b0, 1'b0, 0);
  endtask

  task automatic test_stall();
    $display("[TB] pe_ready stall at address 4");
    run_op(1, 0, 100, 4, 3, -1, 1'b0, 1'b0, 0);
  endtask

  task automatic test_pass_zero();
    $display("[TB] pass_cfg zero runs one sweep");
    run_op(0, 0, 100, -1, 0, -1, 1'b0, 1'b0, 1 + DEPTH + 1 + DEPTH + 1);
  endtask

  task automatic test_reset_mid();
    $display("[TB] reset during run");
    run_op(2, 0, 100, -1, 0, 5, 1'b0, 1'b0, 0);
    run_op(1, 0, 100, -1, 0, -1, 1'b0, 1'b0, 1 + DEPTH + 1 + DEPTH + 1);
  endtask

  task automatic test_ignored();
    $display("[TB] ignored w_valid in idle and load_start while busy");
    for (int i = 0; i < 5; i++) begin
      @(negedge sclk);
      w_valid = 1'b1; w_data = $urandom;
      @(negedge sclk);
      checks++;
      if (spad_we_en !== 1'b0 || w_ready !== 1'b0 || busy !== 1'b0 || spad_addr_we !== last_addr || spad_data_in !== last_data) begin
        errors++; $display("[TB] FAIL idle_write got we=%b busy=%b addr=%0d exp 0 0 %0d", spad_we_en, busy, spad_addr_we, last_addr);
      end
    end
    w_valid = 1'b0;
    run_op(2, 0, 100, -1, 0, -1, 1'b1, 1'b0, 1 + DEPTH + 1 + DEPTH * 2 + 1);
  endtask

  task automatic test_random();
    $display("[TB] randomized operations");
    for (int n = 0; n < 8; n++) begin
      run_op($urandom_range(0, 4), $urandom_range(0, 2), 65, -1, 0, -1, 1'($urandom_range(0, 1)), 1'b0, 0);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; load_start = 1'b0; pass_cfg = 8'd0;
    w_valid = 1'b0; w_data = '0; pe_ready = 1'b0;
    last_addr = '0; last_data = '0;
    test_reset();
    test_basic();
    test_valid_toggle();
    test_stall();
    test_pass_zero();
    test_reset_mid();
    test_ignored();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spad_w_ctrl.md
SPAD_W_CTRL -- requirements
Module: spad_w_ctrl

Interface
REQ-001 SHALL have parameter WEIGHT_DW, default 32, width of one weight word.
REQ-002 SHALL have parameter DEPTH, default 8, number of weight scratchpad entries; DEPTH >= 2, not required to be a power of two.
REQ-003 SHALL define AW = $clog2(DEPTH) as the address width.
REQ-004 sclk  in  1  clock; all state updates on posedge.
REQ-005 rst  in  1  reset; one clock, reset is asynchronous and active-high.
REQ-006 load_start  in  1  single-cycle request to load and run one weight set.
REQ-007 pass_cfg  in  8  number of read sweeps over the scratchpad; sampled with load_start.
REQ-008 w_valid  in  1  upstream weight word valid.
REQ-009 w_data  in  WEIGHT_DW  upstream weight word, signed.
REQ-010 w_ready  out  1  controller accepts a weight word.
REQ-011 spad_we_en  out  1  scratchpad write enable.
REQ-012 spad_addr_we  out  AW  scratchpad write address.
REQ-013 spad_data_in  out  WEIGHT_DW  scratchpad write data.
REQ-014 spad_addr_re  out  AW  scratchpad read address.
REQ-015 pe_ready  in  1  downstream PE accepts the current weight.
REQ-016 pe_valid  out  1  weight at spad_addr_re is valid for the PE.
REQ-017 pe_last  out  1  current beat is the last entry of a sweep.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 done  out  1  one-cycle pulse when the final sweep completes.

Function
REQ-020 FSM states: IDLE, LOAD, SETTLE, RUN.
REQ-021 IDLE: on load_start -> LOAD next cycle; latch pass_cfg, with 0 treated as 1; clear write and read counters.
REQ-022 load_start SHALL be ignored outside IDLE.
REQ-023 w_ready SHALL be registered and high exactly while state is LOAD; w_valid outside LOAD is ignored.
REQ-024 On each posedge with w_valid && w_ready: spad_we_en = 1, spad_addr_we = write count, spad_data_in = w_data, all registered; write count increments.
REQ-025 On cycles with no accepted beat, spad_we_en SHALL be 0, and spad_addr_we and spad_data_in SHALL hold their values.
REQ-026 After the DEPTH-th accepted beat: LOAD -> SETTLE, and w_ready drops the following cycle.
REQ-027 SETTLE lasts exactly one cycle -> RUN. This guarantees the last write (captured by the scratchpad on the negedge) completes and spad_we_en is 0 before any read.
REQ-028 pe_valid SHALL be high exactly while state is RUN, and never while spad_we_en is 1.
REQ-029 A beat transfers on pe_valid && pe_ready; on transfer spad_addr_re advances, wrapping DEPTH-1 -> 0.
REQ-030 Without a transfer, spad_addr_re holds.
REQ-031 pe_last = pe_valid && spad_addr_re == DEPTH-1.
REQ-032 The sweep counter increments on each transfer with pe_last.
REQ-033 On the transfer that completes sweep number pass_cfg: RUN -> IDLE, and done is pulsed high for exactly the next cycle.
REQ-034 Minimum latency from load_start to done, with no stalls: 1 + DEPTH + 1 + DEPTH*passes + 1 cycles.

Reset
REQ-035 rst high SHALL immediately force IDLE and clear all counters.
REQ-036 While rst is high, every output SHALL be 0: w_ready, spad_we_en, spad_addr_we, spad_data_in, spad_addr_re, pe_valid, pe_last, busy, done.
REQ-037 Reset mid-operation SHALL abandon the operation with no done pulse; the next load_start after release SHALL behave as from power-up.

Structure
REQ-038 Shared package spad_pkg SHALL hold the WEIGHT_DW and DEPTH defaults and the FSM state encoding.
REQ-039 One sub-module, spad_addr_cnt (mod-DEPTH counter with enable, clear and wrap flag), SHALL be instantiated twice: write counter and read counter.

Verification (DEPTH=8, WEIGHT_DW=32)
REQ-040 load_start with pass_cfg=2, w_data 0x11..0x88 streamed back-to-back, pe_ready=1 -> spad_addr_we 0..7 over 8 consecutive write cycles; 1 SETTLE cycle; 16 reads at addresses 0..7,0..7; pe_last on beats 8 and 16; done pulses 27 cycles after load_start.
REQ-041 w_valid toggling 1,0,1,0... -> exactly 8 writes, addresses 0..7, no address skipped or repeated, spad_we_en low on idle cycles.
REQ-042 pe_ready low for 3 cycles while spad_addr_re=4 -> spad_addr_re holds 4 and pe_valid stays 1; sequence resumes at 5.
REQ-043 pass_cfg=0 -> exactly one sweep (8 beats), then done.
REQ-044 rst pulsed while spad_addr_re=5 in RUN -> all outputs 0 immediately, no done pulse; a following load_start completes a normal load and run.
REQ-045 load_start asserted during RUN, and w_valid asserted during IDLE -> no state change and no scratchpad write.
